accum_control_fsm: RTL
======================

ACCUM_CONTROL_FSM -- requirements
Module: accum_control_fsm

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port ir_op, input, 5 bits: opcode field held by the instruction register (instruction bits [4:0]).
REQ-004 SHALL have port acc_zero, input, 1 bit: accumulator equals 0.
REQ-005 SHALL have port mem_ready, input, 1 bit: memory completes the current read or write this cycle.
REQ-006 SHALL have ports ir_write, pc_write, mem_read, mem_write, acc_write, iord (0 = PC address, 1 = IR address field), outputs, 1 bit each: datapath strobes.
REQ-007 SHALL have port pc_src, output, 2 bits: 0 = PC+1, 1 = branch target, 2 = jump target.
REQ-008 SHALL have port acc_src, output, 2 bits: 0 = ALU, 1 = memory data, 2 = immediate.
REQ-009 SHALL have port alu_sub, output, 1 bit: 0 = add, 1 = subtract.
REQ-010 SHALL have ports halted and illegal_op, outputs, 1 bit each: status.
REQ-011 SHALL have port retire_count, output, 16 bits: count of completed instructions.

Function
REQ-012 SHALL implement the states FETCH, DECODE, MEM, EXEC and HALT.
REQ-013 SHALL define the opcodes LOAD=01h, STORE=02h, ADD=03h, SUB=04h, BEQ=05h, JUMP=06h, LOADI=07h and HALT=1Fh; every other value is illegal.
REQ-014 SHALL, in FETCH, assert mem_read with iord=0; on mem_ready it pulses ir_write and pc_write (pc_src=0) in the same cycle and moves to DECODE; otherwise it stays in FETCH with the strobes low.
REQ-015 SHALL, in DECODE, move to MEM for LOAD and STORE, and to EXEC for ADD, SUB and LOADI.
REQ-016 SHALL, in DECODE for BEQ, assert pc_write (pc_src=1) exactly when acc_zero=1, then return to FETCH.
REQ-017 SHALL, in DECODE for JUMP, assert pc_write (pc_src=2), then return to FETCH.
REQ-018 SHALL, in DECODE for HALT, move to HALT.
REQ-019 SHALL, in DECODE for an illegal opcode, pulse illegal_op for 1 cycle, return to FETCH and not count the instruction as retired.
REQ-020 SHALL, in MEM for LOAD, assert mem_read with iord=1; on mem_ready it asserts acc_write (acc_src=1) and moves to FETCH; otherwise it holds in MEM.
REQ-021 SHALL, in MEM for STORE, assert mem_write with iord=1; it holds until mem_ready, then moves to FETCH.
REQ-022 SHALL, in EXEC, assert acc_write for 1 cycle, then move to FETCH: ADD uses acc_src=0, alu_sub=0; SUB uses acc_src=0, alu_sub=1; LOADI uses acc_src=2.
REQ-023 SHALL assume ir_op stable from DECODE through completion, and SHALL NOT latch it.
REQ-024 SHALL keep all strobes 0 in HALT, hold halted=1, and stay in HALT until reset; mem_ready is ignored in HALT.
REQ-025 SHALL increment retire_count by 1 on the last cycle of each legal non-HALT instruction, wrapping from FFFFh to 0000h.
REQ-026 SHALL hold every strobe not explicitly asserted in a state at 0; pc_src, acc_src and alu_sub SHALL be 0 when unused.
REQ-027 SHALL produce strobes as a combinational decode of state, ir_op, acc_zero and mem_ready, so mem_ready-to-strobe latency is 0 cycles.
REQ-028 SHALL give the latencies with zero wait states: LOAD/STORE 3 cycles; ADD/SUB/LOADI 3 cycles; BEQ/JUMP 2 cycles.

Reset
REQ-029 SHALL, on a clock edge with reset=1, set state to FETCH, retire_count to 0, halted to 0 and illegal_op to 0.
REQ-030 SHALL force all strobe outputs to 0 during any cycle in which reset=1.
REQ-031 SHALL treat reset during MEM, EXEC or HALT as aborting the instruction without retiring it; FETCH begins on the first cycle after reset deasserts.

Structure
REQ-032 SHALL place the opcode constants, state encoding, and pc_src/acc_src encodings in shared package accum_ctrl_pkg.
REQ-033 SHALL implement the state register and retire_count in this module.
REQ-034 SHALL implement the combinational opcode decode in the sub-module accum_ctrl_decode (inputs: state, ir_op, acc_zero, mem_ready; outputs: strobes and next state).

Verification
REQ-035 SHALL cover: mem_ready=1 throughout; ir_op sequence LOADI, ADD, STORE -> state order FETCH, DECODE, EXEC, FETCH, DECODE, EXEC, FETCH, DECODE, MEM, FETCH; retire_count=3 after 9 cycles.
REQ-036 SHALL cover: LOAD with mem_ready low for 4 cycles in MEM -> mem_read and iord held high for 5 cycles; acc_write (acc_src=1) only in the mem_ready cycle.
REQ-037 SHALL cover: BEQ with acc_zero=1 -> pc_write=1, pc_src=1 in DECODE; BEQ with acc_zero=0 -> pc_write=0; both increment retire_count.
REQ-038 SHALL cover: ir_op=10h -> illegal_op pulse, return to FETCH, retire_count unchanged; ir_op=1Fh -> halted=1 with strobes 0 for at least 10 cycles despite mem_ready toggling.
REQ-039 SHALL cover: reset asserted in MEM of a STORE -> mem_write=0 in the reset cycle, state=FETCH and retire_count=0 afterwards.
REQ-040 SHALL cover: retire_count preloaded near FFFFh by running 65536 LOADI instructions -> count wraps to 0000h.

Source files
------------

// File: rtl/accum_ctrl_pkg.sv
// Shared types for the accumulator control FSM:
// state encoding, opcodes, mux-select encodings and the strobe bundle.
package accum_ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_MEM    = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_e;

    localparam logic [4:0] OP_LOAD  = 5'h01;
    localparam logic [4:0] OP_STORE = 5'h02;
    localparam logic [4:0] OP_ADD   = 5'h03;
    localparam logic [4:0] OP_SUB   = 5'h04;
    localparam logic [4:0] OP_BEQ   = 5'h05;
    localparam logic [4:0] OP_JUMP  = 5'h06;
    localparam logic [4:0] OP_LOADI = 5'h07;
    localparam logic [4:0] OP_HALT  = 5'h1F;

    localparam logic [1:0] PC_INC    = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JUMP   = 2'd2;

    localparam logic [1:0] ACC_ALU = 2'd0;
    localparam logic [1:0] ACC_MEM = 2'd1;
    localparam logic [1:0] ACC_IMM = 2'd2;

    typedef struct packed {
        logic       ir_write;
        logic       pc_write;
        logic       mem_read;
        logic       mem_write;
        logic       acc_write;
        logic       iord;
        logic [1:0] pc_src;
        logic [1:0] acc_src;
        logic       alu_sub;
    } ctrl_t;

endpackage

// File: rtl/accum_control_fsm_if.sv
// Datapath-facing bundle of the accumulator control FSM:
// instruction/status inputs and datapath strobes.
interface accum_control_fsm_if;

    logic [4:0]  ir_op;
    logic        acc_zero;
    logic        mem_ready;
    logic        ir_write;
    logic        pc_write;
    logic        mem_read;
    logic        mem_write;
    logic        acc_write;
    logic        iord;
    logic [1:0]  pc_src;
    logic [1:0]  acc_src;
    logic        alu_sub;
    logic        halted;
    logic        illegal_op;
    logic [15:0] retire_count;

    modport master (
        output ir_op, acc_zero, mem_ready,
        input  ir_write, pc_write, mem_read, mem_write,
        input  acc_write, iord, pc_src, acc_src, alu_sub,
        input  halted, illegal_op, retire_count
    );

    modport slave (
        input  ir_op, acc_zero, mem_ready,
        output ir_write, pc_write, mem_read, mem_write,
        output acc_write, iord, pc_src, acc_src, alu_sub,
        output halted, illegal_op, retire_count
    );

endinterface

// File: rtl/accum_ctrl_decode.sv
// Combinational next-state and strobe decode; ir_op is read live,
// so the datapath must hold it stable until the instruction completes.
module accum_ctrl_decode
    import accum_ctrl_pkg::*;
(
    input  state_e     state,
    input  logic [4:0] ir_op,
    input  logic       acc_zero,
    input  logic       mem_ready,
    output ctrl_t      ctrl,
    output state_e     state_nxt,
    output logic       illegal,
    output logic       retire
);

    always_comb begin
        ctrl      = '0;
        state_nxt = state;
        illegal   = 1'b0;
        retire    = 1'b0;
        unique case (state)
            S_FETCH: begin
                ctrl.mem_read = 1'b1;
                if (mem_ready) begin
                    ctrl.ir_write = 1'b1;
                    ctrl.pc_write = 1'b1;
                    ctrl.pc_src   = PC_INC;
                    state_nxt     = S_DECODE;
                end
            end
            S_DECODE: begin
                case (ir_op)
                    OP_LOAD, OP_STORE: state_nxt = S_MEM;
                    OP_ADD, OP_SUB, OP_LOADI: state_nxt = S_EXEC;
                    OP_BEQ: begin
                        if (acc_zero) begin
                            ctrl.pc_write = 1'b1;
                            ctrl.pc_src   = PC_BRANCH;
                        end
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                    OP_JUMP: begin
                        ctrl.pc_write = 1'b1;
                        ctrl.pc_src   = PC_JUMP;
                        retire        = 1'b1;
                        state_nxt     = S_FETCH;
                    end
                    OP_HALT: state_nxt = S_HALT;
                    default: begin
                        illegal   = 1'b1;
                        state_nxt = S_FETCH;
                    end
                endcase
            end
            S_MEM: begin
                if (ir_op == OP_LOAD) begin
                    ctrl.mem_read = 1'b1;
                    ctrl.iord     = 1'b1;
                    if (mem_ready) begin
                        ctrl.acc_write = 1'b1;
                        ctrl.acc_src   = ACC_MEM;
                        retire         = 1'b1;
                        state_nxt      = S_FETCH;
                    end
                end else if (ir_op == OP_STORE) begin
                    ctrl.mem_write = 1'b1;
                    ctrl.iord      = 1'b1;
                    if (mem_ready) begin
                        retire    = 1'b1;
                        state_nxt = S_FETCH;
                    end
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_EXEC: begin
                state_nxt = S_FETCH;
                case (ir_op)
                    OP_ADD: begin
                        ctrl.acc_write = 1'b1;
                        ctrl.acc_src   = ACC_ALU;
                        retire         = 1'b1;
                    end
                    OP_SUB: begin
                        ctrl.acc_write = 1'b1;
                        ctrl.acc_src   = ACC_ALU;
                        ctrl.alu_sub   = 1'b1;
                        retire         = 1'b1;
                    end
                    OP_LOADI: begin
                        ctrl.acc_write = 1'b1;
                        ctrl.acc_src   = ACC_IMM;
                        retire         = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

endmodule

// File: rtl/accum_control_fsm.sv
// Multi-cycle control FSM for a single-accumulator datapath:
// state register, retire counter and registered status flags.
module accum_control_fsm
    import accum_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    accum_control_fsm_if.slave bus
);

    state_e      state_q, state_d, state_nxt;
    logic [15:0] retire_q, retire_d;
    logic        halted_q, halted_d;
    logic        illegal_q, illegal_d;
    ctrl_t       ctrl, ctrl_o;
    logic        illegal, retire;

    accum_ctrl_decode u_decode (
        .state     (state_q),
        .ir_op     (bus.ir_op),
        .acc_zero  (bus.acc_zero),
        .mem_ready (bus.mem_ready),
        .ctrl      (ctrl),
        .state_nxt (state_nxt),
        .illegal   (illegal),
        .retire    (retire)
    );

    always_comb begin
        state_d   = state_nxt;
        retire_d  = retire_q + {15'd0, retire};
        halted_d  = (state_nxt == S_HALT);
        illegal_d = illegal;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_FETCH;
            retire_q  <= 16'd0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            retire_q  <= retire_d;
            halted_q  <= halted_d;
            illegal_q <= illegal_d;
        end
    end

    // Reset kills every strobe in the same cycle, aborting any bus access.
    assign ctrl_o = reset ? '0 : ctrl;

    assign bus.ir_write     = ctrl_o.ir_write;
    assign bus.pc_write     = ctrl_o.pc_write;
    assign bus.mem_read     = ctrl_o.mem_read;
    assign bus.mem_write    = ctrl_o.mem_write;
    assign bus.acc_write    = ctrl_o.acc_write;
    assign bus.iord         = ctrl_o.iord;
    assign bus.pc_src       = ctrl_o.pc_src;
    assign bus.acc_src      = ctrl_o.acc_src;
    assign bus.alu_sub      = ctrl_o.alu_sub;
    assign bus.halted       = halted_q;
    assign bus.illegal_op   = illegal_q;
    assign bus.retire_count = retire_q;

endmodule
